// File: rtl/medium_pkg.sv
// ---------------------------------------------------------------------------
// medium_pkg
// Shared definitions for the weight burst engine:
//   state_e    - burst FSM states
//   map_addr   - wide-word address + piece index -> BRAM word address
//   idx_width  - width of a piece index (at least one bit)
// ---------------------------------------------------------------------------
package medium_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_ISSUE = 3'd1,
    ST_RD_WAIT  = 3'd2,
    ST_WR_WAIT  = 3'd3,
    ST_WR_ISSUE = 3'd4
  } state_e;

  // Piece p of wide word a lives at BRAM address a*pieces+p.
  function automatic int unsigned map_addr(input int unsigned word,
                                           input int unsigned piece,
                                           input int unsigned pieces);
    return word * pieces + piece;
  endfunction

  // Piece index width; a single-piece word still needs a one-bit index.
  function automatic int idx_width(input int pieces);
    return (pieces > 1) ? $clog2(pieces) : 1;
  endfunction

endpackage

// File: rtl/weight_burst_medium_read_pipe.sv
// ---------------------------------------------------------------------------
// bram_read_pipe
// Delays the (valid, piece index) of every issued BRAM read by BRAM_LATENCY
// cycles so the capture side knows which piece bram_dout carries.
// Ports:
//   clk_in, rst_in      clock, asynchronous active-low reset
//   issue_vld_i/idx_i   a read of piece idx is presented on bram_addr now
//   cap_vld_o/idx_o     bram_dout carries that piece this cycle
// ---------------------------------------------------------------------------
module bram_read_pipe
  import medium_pkg::*;
#(
  parameter  int BRAM_LATENCY = 2,
  parameter  int PIECES       = 48,
  localparam int IDX_W        = idx_width(PIECES)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             issue_vld_i,
  input  logic [IDX_W-1:0] issue_idx_i,
  output logic             cap_vld_o,
  output logic [IDX_W-1:0] cap_idx_o
);

  logic [BRAM_LATENCY-1:0] vld_q;
  logic [IDX_W-1:0]        idx_q [BRAM_LATENCY];

  // Shift register: stage k holds reads issued k+1 cycles ago.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      vld_q <= '0;
      for (int i = 0; i < BRAM_LATENCY; i++) begin
        idx_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= issue_vld_i;
      idx_q[0] <= issue_idx_i;
      for (int i = 1; i < BRAM_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  assign cap_vld_o = vld_q[BRAM_LATENCY-1];
  assign cap_idx_o = idx_q[BRAM_LATENCY-1];

endmodule

// File: rtl/weight_burst_medium.sv
// ---------------------------------------------------------------------------
// weight_burst_medium
// Burst engine that stores WIDTH-bit weight words as PIECES narrow BRAM words.
// Ports:
//   clk_in, rst_in                       clock, asynchronous active-low reset
//   cmd_valid_in/ready_out/write_in      burst command handshake, direction
//   cmd_addr_in, cmd_len_in              first word address, words minus one
//   wdata_in/valid_in/ready_out          write word stream
//   rdata_out/valid_out/last_out/ready_in read word stream
//   busy_out                             high whenever not idle
//   bram_*                               narrow BRAM port (piece 0 = LSBs)
// ---------------------------------------------------------------------------
module weight_burst_medium
  import medium_pkg::*;
#(
  parameter  int ADDRS          = 256,
  parameter  int BRAM_WIDTH     = 64,
  parameter  int PIECES         = 48,
  parameter  int BRAM_LATENCY   = 2,
  localparam int ADDR_SIZE      = $clog2(ADDRS),
  localparam int BRAM_ADDR_SIZE = $clog2(ADDRS * PIECES),
  localparam int WIDTH          = PIECES * BRAM_WIDTH
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      cmd_valid_in,
  output logic                      cmd_ready_out,
  input  logic                      cmd_write_in,
  input  logic [ADDR_SIZE-1:0]      cmd_addr_in,
  input  logic [ADDR_SIZE-1:0]      cmd_len_in,
  input  logic [WIDTH-1:0]          wdata_in,
  input  logic                      wdata_valid_in,
  output logic                      wdata_ready_out,
  output logic [WIDTH-1:0]          rdata_out,
  output logic                      rdata_valid_out,
  output logic                      rdata_last_out,
  input  logic                      rdata_ready_in,
  output logic                      busy_out,
  input  logic [BRAM_WIDTH-1:0]     bram_dout,
  output logic [BRAM_ADDR_SIZE-1:0] bram_addr,
  output logic                      bram_we,
  output logic                      bram_regce,
  output logic [BRAM_WIDTH-1:0]     bram_din
);

  localparam int               IDX_W      = idx_width(PIECES);
  localparam logic [IDX_W-1:0] LAST_PIECE = IDX_W'(PIECES - 1);

  state_e                    state_q;
  logic [ADDR_SIZE-1:0]      addr_q;       // current word address (wrapped)
  logic [ADDR_SIZE-1:0]      cnt_q;        // current word offset in burst
  logic [ADDR_SIZE-1:0]      len_q;
  logic [IDX_W-1:0]          piece_q;      // piece currently on bram_addr
  logic [WIDTH-1:0]          wdata_q;
  logic [WIDTH-1:0]          asm_q;        // read assembly register
  logic                      asm_full_q;   // asm_q holds a complete word
  logic [WIDTH-1:0]          rdata_q;
  logic                      rvalid_q;
  logic                      rlast_q;
  logic                      cmd_ready_q;
  logic                      wdata_ready_q;
  logic                      busy_q;
  logic [BRAM_ADDR_SIZE-1:0] bram_addr_q;
  logic                      bram_we_q;
  logic                      bram_regce_q;
  logic [BRAM_WIDTH-1:0]     bram_din_q;

  logic                      cap_vld_s;
  logic [IDX_W-1:0]          cap_idx_s;
  logic                      last_arrive_s;
  logic [WIDTH-1:0]          merged_s;
  logic [WIDTH-1:0]          load_word_s;
  logic                      rd_load_s;
  logic                      rd_pop_s;
  logic [IDX_W-1:0]          piece_nxt_s;
  logic [ADDR_SIZE-1:0]      addr_nxt_s;

  bram_read_pipe #(
    .BRAM_LATENCY (BRAM_LATENCY),
    .PIECES       (PIECES)
  ) u_read_pipe (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .issue_vld_i (state_q == ST_RD_ISSUE),
    .issue_idx_i (piece_q),
    .cap_vld_o   (cap_vld_s),
    .cap_idx_o   (cap_idx_s)
  );

  // Read handoff decode. The final piece is merged on the fly so a word can
  // reach the output register in the same edge its last piece is sampled.
  always_comb begin
    last_arrive_s = cap_vld_s && (cap_idx_s == LAST_PIECE);
    merged_s      = asm_q;
    merged_s[(PIECES-1)*BRAM_WIDTH +: BRAM_WIDTH] = bram_dout;
    load_word_s   = asm_full_q ? asm_q : merged_s;
    rd_pop_s      = rvalid_q && rdata_ready_in;
    rd_load_s     = (state_q == ST_RD_WAIT) && (asm_full_q || last_arrive_s) &&
                    (!rvalid_q || rdata_ready_in);
    piece_nxt_s   = piece_q + 1'b1;
    addr_nxt_s    = (addr_q == ADDR_SIZE'(ADDRS - 1)) ? '0 : addr_q + 1'b1;
  end

  // Burst FSM with all outputs registered.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      cnt_q         <= '0;
      len_q         <= '0;
      piece_q       <= '0;
      wdata_q       <= '0;
      asm_q         <= '0;
      asm_full_q    <= 1'b0;
      rdata_q       <= '0;
      rvalid_q      <= 1'b0;
      rlast_q       <= 1'b0;
      cmd_ready_q   <= 1'b0;
      wdata_ready_q <= 1'b0;
      busy_q        <= 1'b0;
      bram_addr_q   <= '0;
      bram_we_q     <= 1'b0;
      bram_regce_q  <= 1'b0;
      bram_din_q    <= '0;
    end else begin
      if (cap_vld_s) begin
        asm_q[cap_idx_s*BRAM_WIDTH +: BRAM_WIDTH] <= bram_dout;
      end
      case (state_q)
        ST_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid_in && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            addr_q      <= cmd_addr_in;
            len_q       <= cmd_len_in;
            cnt_q       <= '0;
            piece_q     <= '0;
            asm_full_q  <= 1'b0;
            if (cmd_write_in) begin
              state_q       <= ST_WR_WAIT;
              wdata_ready_q <= 1'b1;
            end else begin
              state_q      <= ST_RD_ISSUE;
              bram_regce_q <= 1'b1;
              bram_addr_q  <= BRAM_ADDR_SIZE'(map_addr(32'(cmd_addr_in), 32'd0, 32'(PIECES)));
            end
          end
        end
        ST_RD_ISSUE: begin
          if (rd_pop_s) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
          end
          if (piece_q == LAST_PIECE) begin
            state_q <= ST_RD_WAIT;
          end else begin
            piece_q     <= piece_nxt_s;
            bram_addr_q <= bram_addr_q + 1'b1;
          end
        end
        ST_RD_WAIT: begin
          if (rd_load_s) begin
            rdata_q    <= load_word_s;
            rvalid_q   <= 1'b1;
            rlast_q    <= (cnt_q == len_q);
            asm_full_q <= 1'b0;
            // Next word's issue starts right after this load.
            if (cnt_q != len_q) begin
              state_q     <= ST_RD_ISSUE;
              cnt_q       <= cnt_q + 1'b1;
              addr_q      <= addr_nxt_s;
              piece_q     <= '0;
              bram_addr_q <= BRAM_ADDR_SIZE'(map_addr(32'(addr_nxt_s), 32'd0, 32'(PIECES)));
            end
          end else begin
            if (last_arrive_s) begin
              asm_full_q <= 1'b1;
            end
            if (rd_pop_s) begin
              rvalid_q <= 1'b0;
              rlast_q  <= 1'b0;
              if (rlast_q) begin
                state_q      <= ST_IDLE;
                busy_q       <= 1'b0;
                bram_regce_q <= 1'b0;
                cmd_ready_q  <= 1'b1;
              end
            end
          end
        end
        ST_WR_WAIT: begin
          if (wdata_valid_in && wdata_ready_q) begin
            wdata_q       <= wdata_in;
            wdata_ready_q <= 1'b0;
            state_q       <= ST_WR_ISSUE;
            piece_q       <= '0;
            bram_we_q     <= 1'b1;
            bram_din_q    <= wdata_in[BRAM_WIDTH-1:0];
            bram_addr_q   <= BRAM_ADDR_SIZE'(map_addr(32'(addr_q), 32'd0, 32'(PIECES)));
          end
        end
        ST_WR_ISSUE: begin
          if (piece_q == LAST_PIECE) begin
            bram_we_q <= 1'b0;
            if (cnt_q == len_q) begin
              state_q     <= ST_IDLE;
              busy_q      <= 1'b0;
              cmd_ready_q <= 1'b1;
            end else begin
              state_q       <= ST_WR_WAIT;
              wdata_ready_q <= 1'b1;
              cnt_q         <= cnt_q + 1'b1;
              addr_q        <= addr_nxt_s;
            end
          end else begin
            piece_q     <= piece_nxt_s;
            bram_addr_q <= bram_addr_q + 1'b1;
            bram_din_q  <= wdata_q[piece_nxt_s*BRAM_WIDTH +: BRAM_WIDTH];
          end
        end
        default: begin
          state_q       <= ST_IDLE;
          busy_q        <= 1'b0;
          cmd_ready_q   <= 1'b0;
          wdata_ready_q <= 1'b0;
          bram_we_q     <= 1'b0;
          bram_regce_q  <= 1'b0;
          rvalid_q      <= 1'b0;
          rlast_q       <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready_out   = cmd_ready_q;
  assign wdata_ready_out = wdata_ready_q;
  assign rdata_out       = rdata_q;
  assign rdata_valid_out = rvalid_q;
  assign rdata_last_out  = rlast_q;
  assign busy_out        = busy_q;
  assign bram_addr       = bram_addr_q;
  assign bram_we         = bram_we_q;
  assign bram_regce      = bram_regce_q;
  assign bram_din        = bram_din_q;

endmodule
